// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared defaults, FSM states and neighbour bit indices for the life stepper
package life_pkg;

  localparam int LIFE_W = 16;
  localparam int LIFE_H = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } life_state_t;

  // Neighbour vector layout: {NW, N, NE, W, E, SW, S, SE}
  localparam int NB_NW = 7;
  localparam int NB_N  = 6;
  localparam int NB_NE = 5;
  localparam int NB_W  = 4;
  localparam int NB_E  = 3;
  localparam int NB_SW = 2;
  localparam int NB_S  = 1;
  localparam int NB_SE = 0;

endpackage

// File: rtl/next_cell_state.sv
// rtl/next_cell_state.sv - combinational life rule for a single cell
module next_cell_state (
  input  logic       i_center,
  input  logic [7:0] i_nbrs,
  output logic       o_next
);

  logic [3:0] w_count;

  always_comb begin
    w_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_count = w_count + {3'd0, i_nbrs[i]};
    end
    o_next = (w_count == 4'd3) || (i_center && (w_count == 4'd2));
  end

endmodule

// File: rtl/life_field_stepper.sv
// rtl/life_field_stepper.sv - toroidal life field, one row per cycle into a shadow, then commit
module life_field_stepper
  import life_pkg::*;
#(
  parameter int W = LIFE_W,
  parameter int H = LIFE_H
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_wr_en,
  input  logic [$clog2(W)-1:0] i_wr_x,
  input  logic [$clog2(H)-1:0] i_wr_y,
  input  logic                 i_wr_val,
  input  logic [$clog2(W)-1:0] i_rd_x,
  input  logic [$clog2(H)-1:0] i_rd_y,
  output logic                 o_rd_val,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [15:0]          o_gen_count
);

  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam logic [YW-1:0] LAST_ROW = YW'(H - 1);

  life_state_t   r_state;
  logic [YW-1:0] r_row;
  logic [W-1:0]  r_field  [H];
  logic [W-1:0]  r_shadow [H];
  logic [15:0]   r_gen;
  logic          r_done;

  logic [YW-1:0] w_up_idx;
  logic [YW-1:0] w_dn_idx;
  logic [W-1:0]  w_up_row;
  logic [W-1:0]  w_cur_row;
  logic [W-1:0]  w_dn_row;
  logic [W-1:0]  w_next_row;

  // Rows wrap vertically; the committed field is only read here, never written, during CALC
  assign w_up_idx  = (r_row == '0) ? LAST_ROW : r_row - YW'(1);
  assign w_dn_idx  = (r_row == LAST_ROW) ? '0 : r_row + YW'(1);
  assign w_up_row  = r_field[w_up_idx];
  assign w_cur_row = r_field[r_row];
  assign w_dn_row  = r_field[w_dn_idx];

  for (genvar gx = 0; gx < W; gx++) begin : g_cell
    localparam int XL = (gx == 0) ? W - 1 : gx - 1;
    localparam int XR = (gx == W - 1) ? 0 : gx + 1;
    logic [7:0] w_nbrs;

    assign w_nbrs[NB_NW] = w_up_row[XL];
    assign w_nbrs[NB_N]  = w_up_row[gx];
    assign w_nbrs[NB_NE] = w_up_row[XR];
    assign w_nbrs[NB_W]  = w_cur_row[XL];
    assign w_nbrs[NB_E]  = w_cur_row[XR];
    assign w_nbrs[NB_SW] = w_dn_row[XL];
    assign w_nbrs[NB_S]  = w_dn_row[gx];
    assign w_nbrs[NB_SE] = w_dn_row[XR];

    next_cell_state u_rule (
      .i_center (w_cur_row[gx]),
      .i_nbrs   (w_nbrs),
      .o_next   (w_next_row[gx])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_gen   <= 16'd0;
      r_done  <= 1'b0;
      for (int y = 0; y < H; y++) begin
        r_field[y]  <= '0;
        r_shadow[y] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A write on the start edge lands before the first row is evaluated
          if (i_wr_en) r_field[i_wr_y][i_wr_x] <= i_wr_val;
          if (i_start) begin
            r_state <= ST_CALC;
            r_row   <= '0;
          end
        end
        ST_CALC: begin
          r_shadow[r_row] <= w_next_row;
          if (r_row == LAST_ROW) r_state <= ST_COMMIT;
          else                   r_row   <= r_row + YW'(1);
        end
        ST_COMMIT: begin
          for (int y = 0; y < H; y++) r_field[y] <= r_shadow[y];
          r_gen   <= r_gen + 16'd1;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_val    = r_field[i_rd_y][i_rd_x];
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = r_done;
  assign o_gen_count = r_gen;

endmodule

// File: tb/tb_life_field_stepper.sv
// tb/tb_life_field_stepper.sv - self-checking bench for life_field_stepper against a toroidal life model
`timescale 1ns/1ps
module tb_life_field_stepper;

  localparam int W = 16;
  localparam int H = 16;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_wr_en, i_wr_val;
  logic [3:0]  i_wr_x, i_wr_y, i_rd_x, i_rd_y;
  logic        o_rd_val, o_busy, o_done;
  logic [15:0] o_gen_count;

  always #5 i_clk = ~i_clk;

  life_field_stepper #(.W(W), .H(H)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_wr_en     (i_wr_en),
    .i_wr_x      (i_wr_x),
    .i_wr_y      (i_wr_y),
    .i_wr_val    (i_wr_val),
    .i_rd_x      (i_rd_x),
    .i_rd_y      (i_rd_y),
    .o_rd_val    (o_rd_val),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_gen_count (o_gen_count)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit m [H][W];
  int m_gen = 0;

  typedef struct {
    string    name;
    bit [8:0] pat;
    bit       exp;
  } vec_t;
  vec_t vecs [9];

  // Offsets indexed by neighbour bit (0 = SE ... 7 = NW)
  int dxs [8] = '{1, 0, -1, 1, -1, 1, 0, -1};
  int dys [8] = '{1, 1, 1, 0, 0, -1, -1, -1};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) m[y][x] = 1'b0;
    m_gen = 0;
  endfunction

  function automatic void model_step();
    bit nx [H][W];
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) n += int'(m[(y + dy + H) % H][(x + dx + W) % W]);
        nx[y][x] = (n == 3) || (m[y][x] && n == 2);
      end
    end
    m = nx;
    m_gen = (m_gen + 1) % 65536;
  endfunction

  task automatic read_cell(input int x, input int y, output int v);
    i_rd_x = 4'(x);
    i_rd_y = 4'(y);
    #1;
    v = int'(o_rd_val);
  endtask

  task automatic check_field(input string name);
    int bad = 0;
    int v;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        read_cell(x, y, v);
        if (v != int'(m[y][x])) bad++;
      end
    chk({name, "_bad_cells"}, bad, 0);
    chk({name, "_gen"}, int'(o_gen_count), m_gen);
    tick();
  endtask

  task automatic write_cell(input int x, input int y, input bit v);
    i_wr_x = 4'(x); i_wr_y = 4'(y); i_wr_val = v; i_wr_en = 1'b1;
    tick();
    i_wr_en = 1'b0;
    m[y][x] = v;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!o_done && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, int'(o_done), 1);
    model_step();
  endtask

  task automatic do_step(input string name);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(name);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    model_clear();
  endtask

  task automatic load_pattern(input bit [8:0] pat);
    write_cell(8, 8, pat[8]);
    for (int b = 0; b < 8; b++) write_cell(8 + dxs[b], 8 + dys[b], pat[b]);
  endtask

  initial begin
    int v, k, cnt;
    bit exp_b;
    vecs[0] = '{"dead_born_3",  9'b0_1110_0000, 1'b1};
    vecs[1] = '{"dead_2_stays", 9'b0_1100_0000, 1'b0};
    vecs[2] = '{"dead_4_stays", 9'b0_1111_0000, 1'b0};
    vecs[3] = '{"dead_8_stays", 9'b0_1111_1111, 1'b0};
    vecs[4] = '{"live_0_dies",  9'b1_0000_0000, 1'b0};
    vecs[5] = '{"live_1_dies",  9'b1_0000_0001, 1'b0};
    vecs[6] = '{"live_2_lives", 9'b1_1000_0001, 1'b1};
    vecs[7] = '{"live_3_lives", 9'b1_0101_0100, 1'b1};
    vecs[8] = '{"live_4_dies",  9'b1_1111_0000, 1'b0};

    i_rst = 1'b1; i_start = 1'b0; i_wr_en = 1'b0; i_wr_val = 1'b0;
    i_wr_x = '0; i_wr_y = '0; i_rd_x = '0; i_rd_y = '0;
    model_clear();
    tick(); tick();
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_done", int'(o_done), 0);
    chk("reset_gen", int'(o_gen_count), 0);
    i_rst = 1'b0;
    tick();
    check_field("reset_field");

    // Blinker: vertical -> horizontal -> vertical
    write_cell(5, 4, 1'b1); write_cell(5, 5, 1'b1); write_cell(5, 6, 1'b1);
    do_step("blink1");
    read_cell(4, 5, v); chk("blink1_cell_4_5", v, 1);
    read_cell(6, 5, v); chk("blink1_cell_6_5", v, 1);
    read_cell(5, 4, v); chk("blink1_cell_5_4", v, 0);
    check_field("blink1");
    do_step("blink2");
    read_cell(5, 6, v); chk("blink2_cell_5_6", v, 1);
    chk("blink2_gen_is_2", int'(o_gen_count), 2);
    check_field("blink2");

    // Block split across all four corners survives the wrap
    do_reset();
    write_cell(0, 0, 1'b1); write_cell(W-1, 0, 1'b1);
    write_cell(0, H-1, 1'b1); write_cell(W-1, H-1, 1'b1);
    do_step("wrap");
    read_cell(0, 0, v); chk("wrap_cell_0_0", v, 1);
    read_cell(W-1, H-1, v); chk("wrap_cell_15_15", v, 1);
    check_field("wrap");

    // Cycle-accurate busy/done window
    do_reset();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("timing_busy_c%0d", c), int'(o_busy), (c >= 1 && c <= H + 1) ? 1 : 0);
      chk($sformatf("timing_done_c%0d", c), int'(o_done), (c == H + 2) ? 1 : 0);
      tick();
    end
    model_step();
    check_field("timing");

    // Start and write mid-step are dropped
    do_reset();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    i_start = 1'b1; i_wr_en = 1'b1; i_wr_x = 4'd3; i_wr_y = 4'd3; i_wr_val = 1'b1;
    tick();
    i_start = 1'b0; i_wr_en = 1'b0;
    wait_done("ignore");
    for (int c = 0; c < 25; c++) tick();
    chk("ignore_gen_once", int'(o_gen_count), 1);
    chk("ignore_idle", int'(o_busy), 0);
    read_cell(3, 3, v); chk("ignore_cell_3_3", v, 0);
    tick();

    // Write on the start edge is seen by the step
    do_reset();
    write_cell(5, 4, 1'b1); write_cell(5, 5, 1'b1);
    i_wr_x = 4'd5; i_wr_y = 4'd6; i_wr_val = 1'b1; i_wr_en = 1'b1; i_start = 1'b1;
    tick();
    i_wr_en = 1'b0; i_start = 1'b0;
    m[6][5] = 1'b1;
    wait_done("wr_start");
    read_cell(4, 5, v); chk("wr_start_cell_4_5", v, 1);
    check_field("wr_start");

    // Held start runs back-to-back steps, next one begins in the done cycle
    i_start = 1'b1;
    tick();
    wait_done("b2b_first");
    tick();
    k = 1;
    while (!o_done && k < 40) begin
      tick();
      k++;
    end
    i_start = 1'b0;
    chk("b2b_done_spacing", k, H + 2);
    model_step();
    tick();
    chk("b2b_idle_after", int'(o_busy), 0);
    check_field("b2b");

    // Reset in cycle 8 of a step aborts it
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    i_rst = 1'b1;
    #2;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_done", int'(o_done), 0);
    chk("midrst_gen", int'(o_gen_count), 0);
    tick();
    i_rst = 1'b0;
    model_clear();
    tick();
    check_field("midrst");

    // Hand-picked rule vectors around (8,8)
    for (int i = 0; i < 9; i++) begin
      load_pattern(vecs[i].pat);
      do_step(vecs[i].name);
      read_cell(8, 8, v);
      chk({vecs[i].name, "_result"}, v, int'(vecs[i].exp));
    end

    // All 512 centre/neighbour patterns
    do_reset();
    for (int p = 0; p < 512; p++) begin
      bit [8:0] pat;
      pat = 9'(p);
      load_pattern(pat);
      do_step($sformatf("exh_%0d", p));
      cnt = $countones(pat[7:0]);
      exp_b = (cnt == 3) || (pat[8] && cnt == 2);
      read_cell(8, 8, v);
      chk($sformatf("exh_%0d_result", p), v, int'(exp_b));
    end
    check_field("exh_field");

    // Random fields against the model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int w = 0; w < 90; w++)
        write_cell($urandom_range(W - 1), $urandom_range(H - 1), 1'($urandom_range(1)));
      for (int s = 0; s < 4; s++) begin
        do_step($sformatf("rand%0d_step%0d", r, s));
        check_field($sformatf("rand%0d_step%0d", r, s));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/life_field_stepper.md
LIFE_FIELD_STEPPER -- requirements
Module: life_field_stepper

Interface
REQ-001 Parameter W, default 16, field width in cells (x = 0..W-1).
REQ-002 Parameter H, default 16, field height in cells (y = 0..H-1).
REQ-003 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  request one generation step; sampled only in IDLE.
REQ-007 i_wr_en  input  1  cell write strobe; honoured only in IDLE.
REQ-008 i_wr_x / i_wr_y  input  $clog2(W) / $clog2(H)  write coordinates.
REQ-009 i_wr_val  input  1  value written to cell (1 = alive).
REQ-010 i_rd_x / i_rd_y  input  $clog2(W) / $clog2(H)  read coordinates.
REQ-011 o_rd_val  output  1  combinational read of the committed field at (i_rd_x, i_rd_y).
REQ-012 o_busy  output  1  high in CALC and COMMIT.
REQ-013 o_done  output  1  one-cycle pulse after each completed generation.
REQ-014 o_gen_count  output  16  completed generations; wraps 16'hFFFF -> 0.

Function
REQ-015 The field SHALL be toroidal: x-1 of 0 is W-1, x+1 of W-1 is 0, and likewise for y.
REQ-016 The FSM states SHALL be IDLE, CALC and COMMIT.
REQ-017 IDLE -> CALC on i_start=1; the row counter is cleared to 0.
REQ-018 CALC SHALL compute one full row per cycle: rows r-1, r and r+1 of the committed field feed W rule instances; the results go to the shadow row r; r increments.
REQ-019 CALC -> COMMIT after row H-1 is computed (H CALC cycles).
REQ-020 COMMIT SHALL copy the shadow field into the committed field and increment o_gen_count; COMMIT -> IDLE after one cycle.
REQ-021 o_done SHALL be high for exactly the first IDLE cycle after COMMIT; the new field and count are visible in that same cycle.
REQ-022 Latency: if i_start is sampled at edge 0, o_busy is high for cycles 1..H+1 and o_done is high in cycle H+2.
REQ-023 The committed field SHALL NOT change during CALC; all rows use generation-N values only.
REQ-024 Neighbour vector per cell: bit7..0 = {NW, N, NE, W, E, SW, S, SE}; cell state = centre.
REQ-025 Rule: a live cell survives with 2 or 3 live neighbours; a dead cell is born with exactly 3; otherwise the cell is dead.
REQ-026 i_start and i_wr_en SHALL be ignored while o_busy=1; they are neither queued nor latched.
REQ-027 If i_wr_en and i_start are both high in IDLE, the write SHALL commit at that edge and the step SHALL use the written value.
REQ-028 i_start held high SHALL start back-to-back steps, each one beginning in the o_done cycle.

Reset
REQ-029 Reset SHALL force: committed and shadow fields all 0; state IDLE; row counter 0; o_gen_count 0; o_busy 0; o_done 0.
REQ-030 Reset asserted during CALC or COMMIT SHALL abort the step immediately; no partial commit survives.

Structure
REQ-031 A shared package life_pkg SHALL hold the default W/H, the FSM state enum and the neighbour bit-index constants.
REQ-032 The combinational rule SHALL be the existing next_cell_state module, instantiated W times in a generate loop; there SHALL be no other sub-module.

Verification
REQ-033 Blinker: set (5,4), (5,5), (5,6), then step -> only (4,5), (5,5), (6,5) alive; step again -> the original cells are restored; o_gen_count=2.
REQ-034 Wrap: set 2x2 block cells (0,0), (W-1,0), (0,H-1), (W-1,H-1), then step -> the same four cells are alive and all others are dead.
REQ-035 Timing: with W=H=16, i_start pulsed at edge 0 -> o_busy high in cycles 1..17; o_done high only in cycle 18.
REQ-036 Ignore: i_start and a write to (3,3) issued in cycle 5 of a step -> exactly one generation is counted and cell (3,3) is unchanged.
REQ-037 Reset mid-step: assert i_rst in cycle 8 of a step -> field all 0, o_busy=0, o_done=0, o_gen_count=0.
REQ-038 Exhaustive rule: for each of the 512 centre/neighbour patterns loaded around (8,8) -> the result at (8,8) after one step matches REQ-025.
